// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths used by both the PC and the fetch
// sequencer, and the fetch state encoding.
package cpu_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 8;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_REQ,
        FS_HOLD,
        FS_HALTED
    } fetch_state_t;

endpackage

// File: rtl/fetch_fsm.sv
// Fetch sequencer control: state register, next-state logic and the
// PC / memory / instruction-register strobes derived from state and inputs.
module fetch_fsm
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic mem_ready_i,
    input  logic ir_ready_i,
    input  logic branch_valid_i,
    input  logic halt_i,
    output logic pc_enable_o,
    output logic pc_load_o,
    output logic mem_req_o,
    output logic ir_we_o,
    output logic ir_valid_o,
    output logic halted_o
);

    fetch_state_t state_q;
    fetch_state_t state_d;

    // State register; reset is asynchronous and active-low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and same-cycle strobes; a redirect beats halt and kills any fetch in flight.
    always_comb begin
        state_d     = state_q;
        pc_enable_o = 1'b0;
        pc_load_o   = 1'b0;
        mem_req_o   = 1'b0;
        ir_we_o     = 1'b0;
        case (state_q)
            FS_IDLE: begin
                if (branch_valid_i) begin
                    pc_load_o = 1'b1;
                    state_d   = FS_REQ;
                end else if (halt_i) begin
                    state_d = FS_HALTED;
                end else begin
                    state_d = FS_REQ;
                end
            end
            FS_REQ: begin
                mem_req_o = 1'b1;
                if (branch_valid_i) begin
                    pc_load_o = 1'b1;
                    state_d   = FS_REQ;
                end else if (mem_ready_i) begin
                    pc_enable_o = 1'b1;
                    ir_we_o     = 1'b1;
                    state_d     = FS_HOLD;
                end
            end
            FS_HOLD: begin
                if (branch_valid_i) begin
                    pc_load_o = 1'b1;
                    state_d   = FS_REQ;
                end else if (ir_ready_i) begin
                    state_d = halt_i ? FS_HALTED : FS_REQ;
                end
            end
            FS_HALTED: begin
                state_d = FS_HALTED;
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    assign ir_valid_o = (state_q == FS_HOLD);
    assign halted_o   = (state_q == FS_HALTED);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch unit: wraps the fetch sequencer with the instruction
// register and the address / branch-target muxes facing the PC and memory.
module fetch_unit #(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_enable,
    output logic               pc_load,
    output logic [ADDR_W-1:0]  pc_load_value,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ready,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] ir_out,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               halt,
    output logic               halted
);

    logic               ir_we;
    logic [INSTR_W-1:0] ir_q;
    logic [INSTR_W-1:0] ir_d;

    fetch_fsm u_fsm (
        .clk            (clk),
        .reset          (reset),
        .mem_ready_i    (mem_ready),
        .ir_ready_i     (ir_ready),
        .branch_valid_i (branch_valid),
        .halt_i         (halt),
        .pc_enable_o    (pc_enable),
        .pc_load_o      (pc_load),
        .mem_req_o      (mem_req),
        .ir_we_o        (ir_we),
        .ir_valid_o     (ir_valid),
        .halted_o       (halted)
    );

    // Instruction register next value: capture returned data only on an accepted fetch.
    always_comb begin
        ir_d = ir_q;
        if (ir_we) begin
            ir_d = mem_rdata;
        end
    end

    // Instruction register; cleared asynchronously so a reset never exposes stale code.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q <= '0;
        end else begin
            ir_q <= ir_d;
        end
    end

    assign ir_out        = ir_q;
    assign pc_load_value = pc_load ? branch_target : '0;
    assign mem_addr      = mem_req ? pc_in : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a tiny PC model, a scoreboard of
// expected fetch addresses and consumed instructions, and a negedge monitor.
module tb_fetch_unit;

    logic       clk;
    logic       reset;
    logic [7:0] pc;
    logic       pc_enable;
    logic       pc_load;
    logic [7:0] pc_load_value;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ready;
    logic [7:0] mem_rdata;
    logic [7:0] ir_out;
    logic       ir_valid;
    logic       ir_ready;
    logic       branch_valid;
    logic [7:0] branch_target;
    logic       halt;
    logic       halted;

    logic       tbLoad;
    logic [7:0] tbVal;

    int checks;
    int errors;
    int reqCount;
    int enCount;
    int reqBase;
    int enBase;

    logic [7:0] expAddr[$];
    logic [7:0] expInstr[$];

    fetch_unit #(.ADDR_W(8), .INSTR_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_in         (pc),
        .pc_enable     (pc_enable),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .ir_out        (ir_out),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .halt          (halt),
        .halted        (halted)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PC model: bench preload beats branch load, which beats increment.
    always @(posedge clk) begin
        if (tbLoad) begin
            pc <= tbVal;
        end else if (pc_load) begin
            pc <= pc_load_value;
        end else if (pc_enable) begin
            pc <= pc + 8'd1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: scores completed fetches and consumed instructions against the queues.
    always @(negedge clk) begin
        if (mem_req) reqCount++;
        if (pc_enable) enCount++;
        if (pc_enable && pc_load) begin
            checkOutput("enable_load_exclusive", 32'(pc_load), 32'd0);
        end
        if (mem_req && mem_ready && !branch_valid) begin
            if (expAddr.size() == 0) begin
                checkOutput("unexpected_fetch", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                checkOutput("fetch_addr", 32'(mem_addr), 32'(expAddr.pop_front()));
            end
        end
        if (ir_valid && ir_ready && !branch_valid) begin
            if (expInstr.size() == 0) begin
                checkOutput("unexpected_instr", 32'(ir_out), 32'hFFFF_FFFF);
            end else begin
                checkOutput("instr", 32'(ir_out), 32'(expInstr.pop_front()));
            end
        end
    end

    initial begin
        checks = 0; errors = 0; reqCount = 0; enCount = 0;
        reset = 1'b0; tbLoad = 1'b1; tbVal = 8'h00;
        mem_ready = 1'b1; mem_rdata = 8'hA5; ir_ready = 1'b1;
        branch_valid = 1'b0; branch_target = 8'h00; halt = 1'b0;
        expAddr.push_back(8'h00); expAddr.push_back(8'h01);
        expInstr.push_back(8'hA5); expInstr.push_back(8'hA5);

        // Reset and zero-wait memory
        applyStimulus(2);
        checkOutput("rst_ir_out", 32'(ir_out), 32'h0);
        checkOutput("rst_ir_valid", 32'(ir_valid), 32'h0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'h0);
        checkOutput("rst_halted", 32'(halted), 32'h0);
        tbLoad = 1'b0;
        reset = 1'b1;
        applyStimulus(1);
        checkOutput("zw_mem_req", 32'(mem_req), 32'h1);
        checkOutput("zw_mem_addr", 32'(mem_addr), 32'h00);
        checkOutput("zw_pc_enable", 32'(pc_enable), 32'h1);
        checkOutput("zw_ir_valid_early", 32'(ir_valid), 32'h0);
        applyStimulus(1);
        checkOutput("zw_ir_valid", 32'(ir_valid), 32'h1);
        checkOutput("zw_ir_out", 32'(ir_out), 32'hA5);
        checkOutput("zw_pc_inc", 32'(pc), 32'h01);
        checkOutput("zw_hold_no_req", 32'(mem_req), 32'h0);
        applyStimulus(1);
        checkOutput("zw_second_req", 32'(mem_addr), 32'h01);
        applyStimulus(1);

        // Memory wait states at 0x10
        tbLoad = 1'b1; tbVal = 8'h10; mem_ready = 1'b0; mem_rdata = 8'h3C;
        expAddr.push_back(8'h10);
        applyStimulus(1);
        tbLoad = 1'b0; ir_ready = 1'b0;
        reqBase = reqCount; enBase = enCount;
        for (int i = 0; i < 3; i++) begin
            checkOutput("ws_mem_addr", 32'(mem_addr), 32'h10);
            checkOutput("ws_pc_stable", 32'(pc), 32'h10);
            checkOutput("ws_no_enable", 32'(pc_enable), 32'h0);
            applyStimulus(1);
        end
        mem_ready = 1'b1;
        #1;
        checkOutput("ws_ready_enable", 32'(pc_enable), 32'h1);
        applyStimulus(1);
        checkOutput("ws_req_cycles", 32'(reqCount - reqBase), 32'd4);
        checkOutput("ws_enable_count", 32'(enCount - enBase), 32'd1);
        checkOutput("ws_ir_out", 32'(ir_out), 32'h3C);
        checkOutput("ws_pc_after", 32'(pc), 32'h11);

        // Downstream stall in HOLD
        reqBase = reqCount; enBase = enCount;
        for (int i = 0; i < 5; i++) begin
            checkOutput("st_ir_valid", 32'(ir_valid), 32'h1);
            checkOutput("st_ir_out", 32'(ir_out), 32'h3C);
            checkOutput("st_no_req", 32'(mem_req), 32'h0);
            applyStimulus(1);
        end
        checkOutput("st_req_count", 32'(reqCount - reqBase), 32'd0);
        checkOutput("st_en_count", 32'(enCount - enBase), 32'd0);

        // Branch in HOLD with ir_ready also high
        branch_valid = 1'b1; branch_target = 8'h40; ir_ready = 1'b1;
        #1;
        checkOutput("bh_pc_load", 32'(pc_load), 32'h1);
        checkOutput("bh_load_value", 32'(pc_load_value), 32'h40);
        checkOutput("bh_no_enable", 32'(pc_enable), 32'h0);
        applyStimulus(1);
        checkOutput("bh_ir_valid_drop", 32'(ir_valid), 32'h0);
        checkOutput("bh_mem_req", 32'(mem_req), 32'h1);
        checkOutput("bh_mem_addr", 32'(mem_addr), 32'h40);

        // Branch coinciding with mem_ready in REQ
        branch_valid = 1'b1; branch_target = 8'h80; mem_ready = 1'b1; mem_rdata = 8'h77;
        #1;
        checkOutput("br_pc_load", 32'(pc_load), 32'h1);
        checkOutput("br_load_value", 32'(pc_load_value), 32'h80);
        checkOutput("br_no_enable", 32'(pc_enable), 32'h0);
        applyStimulus(1);
        branch_valid = 1'b0; mem_rdata = 8'h5A;
        expAddr.push_back(8'h80); expInstr.push_back(8'h5A);
        #1;
        checkOutput("br_ir_kept", 32'(ir_out), 32'h3C);
        checkOutput("br_ir_valid", 32'(ir_valid), 32'h0);
        checkOutput("br_mem_addr", 32'(mem_addr), 32'h80);
        checkOutput("br_load_value_idle", 32'(pc_load_value), 32'h00);
        checkOutput("br_en_count", 32'(enCount - enBase), 32'd0);
        applyStimulus(1);
        checkOutput("br_new_ir", 32'(ir_out), 32'h5A);

        // Halt on the next accepted instruction
        halt = 1'b1;
        applyStimulus(1);
        checkOutput("h_halted", 32'(halted), 32'h1);
        checkOutput("h_ir_valid", 32'(ir_valid), 32'h0);
        checkOutput("h_mem_req", 32'(mem_req), 32'h0);
        branch_valid = 1'b1; branch_target = 8'h22;
        #1;
        checkOutput("h_no_pc_load", 32'(pc_load), 32'h0);
        applyStimulus(2);
        branch_valid = 1'b0;
        checkOutput("h_still_halted", 32'(halted), 32'h1);
        checkOutput("h_pc_unchanged", 32'(pc), 32'h81);

        // Reset while a request is pending
        halt = 1'b0; mem_ready = 1'b0;
        reset = 1'b0; tbLoad = 1'b1; tbVal = 8'h30;
        #1;
        checkOutput("rr_halted_clear", 32'(halted), 32'h0);
        applyStimulus(1);
        tbLoad = 1'b0; reset = 1'b1;
        applyStimulus(1);
        checkOutput("rr_req", 32'(mem_req), 32'h1);
        checkOutput("rr_addr", 32'(mem_addr), 32'h30);
        applyStimulus(1);
        reset = 1'b0;
        #1;
        checkOutput("rr_async_req", 32'(mem_req), 32'h0);
        checkOutput("rr_async_addr", 32'(mem_addr), 32'h00);
        checkOutput("rr_async_ir", 32'(ir_out), 32'h00);
        checkOutput("rr_async_valid", 32'(ir_valid), 32'h0);
        checkOutput("rr_async_enable", 32'(pc_enable), 32'h0);
        mem_ready = 1'b1; mem_rdata = 8'hC3; ir_ready = 1'b1;
        expAddr.push_back(8'h30); expInstr.push_back(8'hC3);
        applyStimulus(1);
        reset = 1'b1;
        applyStimulus(1);
        checkOutput("rr_restart_addr", 32'(mem_addr), 32'h30);
        applyStimulus(1);
        mem_ready = 1'b0;
        checkOutput("rr_restart_ir", 32'(ir_out), 32'hC3);
        applyStimulus(2);

        checkOutput("sb_addr_drained", 32'(expAddr.size()), 32'd0);
        checkOutput("sb_instr_drained", 32'(expInstr.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch sequencer sitting directly around the program counter. Presents the current PC to instruction memory and waits for the memory handshake. Captures the returned byte into an instruction register, offers it downstream with a valid/ready handshake, and drives the PC's `enable`/`load`/`load_value` inputs. Also absorbs branch redirects from the execute stage, flushing any wrong-path fetch.

## Interface
Parameters:
- `ADDR_W`, 8, PC / instruction-memory address width; must match the PC.
- `INSTR_W`, 8, instruction width.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc_in`  in  ADDR_W  current PC value (PC `pc_out`).
- `pc_enable`  out  ADDR_W→1  increment strobe to PC, 1 bit.
- `pc_load`  out  1  load strobe to PC.
- `pc_load_value`  out  ADDR_W  branch target to PC.
- `mem_req`  out  1  instruction-memory read request.
- `mem_addr`  out  ADDR_W  read address.
- `mem_ready`  in  1  read data valid this cycle.
- `mem_rdata`  in  INSTR_W  read data.
- `ir_out`  out  INSTR_W  instruction register.
- `ir_valid`  out  1  `ir_out` holds a fetched instruction.
- `ir_ready`  in  1  downstream consumes `ir_out` this cycle.
- `branch_valid`  in  1  redirect request from execute (single-cycle pulse).
- `branch_target`  in  ADDR_W  redirect address.
- `halt`  in  1  level; stop fetching at next instruction boundary.
- `halted`  out  1  unit is in HALTED.

## Operation
The state machine has four states: IDLE, REQ, HOLD and HALTED.

- **Async reset** (`reset`=0):
  - State goes to IDLE.
  - `ir_out` is cleared to 0.
  - All strobes, `ir_valid` and `halted` are 0.
  - Any outstanding `mem_req` is abandoned; memory must tolerate this.
- **IDLE:** no request. Next state is HALTED if `halt`, otherwise REQ.
- **REQ:**
  - `mem_req`=1 and `mem_addr`=`pc_in`, held stable until `mem_ready`.
  - On `mem_ready` with no `branch_valid`:
    - `ir_out` ← `mem_rdata`.
    - `pc_enable`=1 this cycle, so the PC increments at the same edge.
    - Next state is HOLD.
- **HOLD:**
  - `ir_valid`=1 and `mem_req`=0; `ir_out` is held.
  - On `ir_ready`: next state is HALTED if `halt`, otherwise REQ.
- **HALTED:**
  - `halted`=1; all other outputs are inactive.
  - `branch_valid` and `ir_ready` are ignored.
  - The only exit is reset.
- **Branch** (`branch_valid`=1 in IDLE, REQ or HOLD):
  - `pc_load`=1 and `pc_load_value`=`branch_target`, combinationally in the same cycle.
  - Next state is REQ.
  - In REQ with `mem_ready` in the same cycle, the returned data is discarded: no IR write, no `pc_enable`.
  - In HOLD, the wrong-path instruction is flushed and `ir_valid` falls at the next edge, even if `ir_ready` was also high.
  - Branch takes priority over `halt` in that cycle.
- **Invariants:**
  - `pc_enable` and `pc_load` are never high together.
  - `pc_enable` is only ever high in REQ with `mem_ready`.
  - The PC never changes while `mem_req` is pending without a branch.
- `pc_load_value` = `branch_target` whenever `branch_valid`, and 0 otherwise.

## Timing
- All outputs are registered state decodes, except that `pc_enable`, `pc_load`, `pc_load_value`, `mem_addr` and `mem_req` are combinational from state plus the same-cycle inputs.
- Reset release: IDLE for 1 cycle, then REQ.
- Zero-wait memory (`mem_ready` in the first REQ cycle): REQ lasts 1 cycle.
  - Edge N: `ir_valid` is asserted and the PC has incremented.
  - With `ir_ready` held high, steady-state throughput is one instruction per 2 cycles.
- Memory wait states extend REQ 1:1.
- Downstream stalls (`ir_ready`=0) extend HOLD indefinitely with `ir_out` held.
- Branch-to-first-request latency: 1 cycle. The new address appears on `mem_addr` in the cycle after `branch_valid`.

## Structure
- Shared package `cpu_pkg`:
  - state enum `fetch_state_t` (FS_IDLE, FS_REQ, FS_HOLD, FS_HALTED);
  - constants `ADDR_W`=8 and `INSTR_W`=8, shared with the PC.
- Sub-module `fetch_fsm`: state register with async active-low reset, next-state logic and strobe decode.
- The top level instantiates `fetch_fsm` plus the IR register with its write enable.

## Test plan
- **Reset, then zero-wait memory:** `pc_in`=0x00, `mem_ready`=1, `mem_rdata`=0xA5, `ir_ready`=1 → `mem_addr`=0x00, a `pc_enable` pulse, and `ir_out`=0xA5 with `ir_valid` at 2 cycles after reset release; requests repeat every 2 cycles.
- **Memory wait states:** `mem_ready` delayed 3 cycles with `pc_in`=0x10 → `mem_req` high for 4 cycles with `mem_addr` stable at 0x10; exactly one `pc_enable`.
- **Downstream stall:** `ir_ready`=0 for 5 cycles in HOLD → `ir_out` and `ir_valid` held, no `mem_req`, no `pc_enable`.
- **Branch in HOLD, and branch coinciding with `mem_ready`:**
  - `branch_valid`, `branch_target`=0x40 in HOLD → `pc_load`=1 with `pc_load_value`=0x40, `ir_valid` drops next cycle, next `mem_addr`=0x40.
  - Branch coinciding with `mem_ready` in REQ → IR unchanged and no `pc_enable`.
- **Halt:** `halt`=1, then `ir_ready` accepted → HALTED, `halted`=1; later `branch_valid` produces no `pc_load`.
- **Reset mid-REQ:** assert `reset`=0 while `mem_req`=1 → all outputs and `ir_out` are 0 immediately (asynchronously); fetch restarts at `pc_in` after release.
